// File: rtl/fifo_pop_arbiter.sv
// Round-robin pop arbiter and threshold/control-bus sequencer for a bank of small FIFOs.
// Optional FIFO_ALMFULL_PRIO_EN: restrict arbitration to almost-full FIFOs when any are pending.
`timescale 1ns/1ps
module fifo_pop_arbiter #(
  parameter int          N_FIFO  = 4,
  parameter logic [2:0]  DEF_SUP = 3'd6,
  parameter logic [2:0]  DEF_INF = 3'd1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [2:0]        cfg_sup,
  input  logic [2:0]        cfg_inf,
  input  logic [N_FIFO-1:0] fifo_empty,
  input  logic [N_FIFO-1:0] fifo_alm_full,
  input  logic              down_alm_full,
  output logic [3:0]        state,
  output logic [2:0]        um_sup,
  output logic [2:0]        um_inf,
  output logic [N_FIFO-1:0] pop,
  output logic              out_valid,
  output logic [2:0]        out_src,
  output logic              cfg_err
);

  typedef enum logic [3:0] {
    ST_RESET  = 4'b0001,
    ST_INIT   = 4'b0010,
    ST_IDLE   = 4'b0100,
    ST_ACTIVE = 4'b1000
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  rr_ptr_q, rr_ptr_d;
  logic [2:0]  um_sup_q, um_sup_d;
  logic [2:0]  um_inf_q, um_inf_d;
  logic        cfg_err_q, cfg_err_d;
  logic        out_valid_q, out_valid_d;
  logic [2:0]  out_src_q, out_src_d;

  logic [N_FIFO-1:0] elig;
  logic [7:0]        elig8;
  logic [7:0]        pop8;
  logic              gnt_found;
  logic [2:0]        gnt_idx;
  logic [3:0]        sum;
  logic              cfg_load;
  logic [N_FIFO-1:0] pop_c;

`ifdef FIFO_ALMFULL_PRIO_EN
  always_comb begin
    elig = ~fifo_empty;
    if (|(elig & fifo_alm_full)) elig = elig & fifo_alm_full;
  end
`else
  logic unused_alm_full;
  assign unused_alm_full = ^fifo_alm_full;
  assign elig = ~fifo_empty;
`endif

  // First eligible index at or above rr_ptr, wrapping at N_FIFO-1.
  always_comb begin
    elig8     = 8'(elig);
    gnt_found = 1'b0;
    gnt_idx   = 3'd0;
    sum       = 4'd0;
    for (int i = 0; i < N_FIFO; i++) begin
      sum = {1'b0, rr_ptr_q} + 4'(i);
      if (sum >= 4'(N_FIFO)) sum = sum - 4'(N_FIFO);
      if (!gnt_found && elig8[sum[2:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = sum[2:0];
      end
    end
    pop8 = 8'b1 << gnt_idx;
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    um_sup_d    = um_sup_q;
    um_inf_d    = um_inf_q;
    cfg_err_d   = cfg_err_q;
    out_src_d   = out_src_q;
    cfg_load    = 1'b0;
    pop_c       = '0;

    case (state_q)
      ST_RESET: begin
        state_d  = ST_INIT;
        cfg_load = 1'b1;
      end
      ST_INIT: begin
        if (!init) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (init) begin
          state_d  = ST_INIT;
          cfg_load = 1'b1;
        end else if (|(~fifo_empty)) begin
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        // init preempts any pop in the same cycle
        if (init) begin
          state_d  = ST_INIT;
          cfg_load = 1'b1;
        end else if (!gnt_found) begin
          state_d = ST_IDLE;
        end else if (!down_alm_full) begin
          pop_c    = pop8[N_FIFO-1:0];
          rr_ptr_d = (gnt_idx == 3'(N_FIFO - 1)) ? 3'd0 : gnt_idx + 3'd1;
        end
      end
      default: state_d = ST_RESET;
    endcase

    if (cfg_load) begin
      if (cfg_sup > cfg_inf) begin
        um_sup_d  = cfg_sup;
        um_inf_d  = cfg_inf;
        cfg_err_d = 1'b0;
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    out_valid_d = |pop_c;
    if (|pop_c) out_src_d = gnt_idx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RESET;
      rr_ptr_q    <= 3'd0;
      um_sup_q    <= DEF_SUP;
      um_inf_q    <= DEF_INF;
      cfg_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_src_q   <= 3'd0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      um_sup_q    <= um_sup_d;
      um_inf_q    <= um_inf_d;
      cfg_err_q   <= cfg_err_d;
      out_valid_q <= out_valid_d;
      out_src_q   <= out_src_d;
    end
  end

  assign state     = state_q;
  assign um_sup    = um_sup_q;
  assign um_inf    = um_inf_q;
  assign cfg_err   = cfg_err_q;
  assign out_valid = out_valid_q;
  assign out_src   = out_src_q;
  assign pop       = pop_c;

endmodule

// File: tb/tb_fifo_pop_arbiter.sv
// Randomized bench for fifo_pop_arbiter: reference model predicts state/pop per cycle,
// a scoreboard queue carries expected (out_valid, out_src) to a posedge monitor.
`timescale 1ns/1ps
module tb_fifo_pop_arbiter;
  localparam int N = 4;
  localparam logic [2:0] DSUP = 3'd6;
  localparam logic [2:0] DINF = 3'd1;

  logic          clk, reset, init, down_alm_full;
  logic [2:0]    cfg_sup, cfg_inf;
  logic [N-1:0]  fifo_empty, fifo_alm_full;
  logic [3:0]    state;
  logic [2:0]    um_sup, um_inf, out_src;
  logic [N-1:0]  pop;
  logic          out_valid, cfg_err;

  fifo_pop_arbiter #(.N_FIFO(N), .DEF_SUP(DSUP), .DEF_INF(DINF)) dut (
    .clk(clk), .reset(reset), .init(init), .cfg_sup(cfg_sup), .cfg_inf(cfg_inf),
    .fifo_empty(fifo_empty), .fifo_alm_full(fifo_alm_full), .down_alm_full(down_alm_full),
    .state(state), .um_sup(um_sup), .um_inf(um_inf), .pop(pop),
    .out_valid(out_valid), .out_src(out_src), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { bit v; int src; } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  // Model: mode 0=reset 1=init 2=idle 3=active; bus code is one-hot 1<<mode.
  int         m_mode;
  int         m_rr;
  logic [2:0] m_sup, m_inf;
  logic       m_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_rr = 0; m_sup = DSUP; m_inf = DINF; m_err = 1'b0;
  endtask

  function automatic int pick(input logic [N-1:0] emp, input logic [N-1:0] almf, input int ptr);
    logic [N-1:0] el;
    int best, bestd, d;
    el = ~emp;
`ifdef FIFO_ALMFULL_PRIO_EN
    if ((el & almf) != 0) el = el & almf;
`endif
    best = -1; bestd = N;
    for (int i = 0; i < N; i++) begin
      d = (i - ptr + N) % N;
      if (el[i] && d < bestd) begin best = i; bestd = d; end
    end
    return best;
  endfunction

  task automatic enter_init(input logic [2:0] s, input logic [2:0] f);
    m_mode = 1;
    if (s > f) begin m_sup = s; m_inf = f; m_err = 1'b0; end
    else m_err = 1'b1;
  endtask

  task automatic step(input logic i_init, input logic [2:0] s, input logic [2:0] f,
                      input logic [N-1:0] emp, input logic [N-1:0] almf, input logic daf);
    int g;
    logic [N-1:0] ep;
    exp_t e;
    @(negedge clk);
    init = i_init; cfg_sup = s; cfg_inf = f;
    fifo_empty = emp; fifo_alm_full = almf; down_alm_full = daf;
    #1;
    g  = pick(emp, almf, m_rr);
    ep = '0;
    if (m_mode == 3 && !i_init && !daf && g >= 0) ep = N'(1) << g;
    chk("state", 32'(state), 32'(4'b1 << m_mode));
    chk("pop", 32'(pop), 32'(ep));
    chk("um_sup", 32'(um_sup), 32'(m_sup));
    chk("um_inf", 32'(um_inf), 32'(m_inf));
    chk("cfg_err", 32'(cfg_err), 32'(m_err));
    e.v = (ep != 0); e.src = g;
    sb.push_back(e);
    case (m_mode)
      0: enter_init(s, f);
      1: if (!i_init) m_mode = 2;
      2: if (i_init) enter_init(s, f); else if (emp != '1) m_mode = 3;
      default: begin
        if (i_init) enter_init(s, f);
        else if (emp == '1) m_mode = 2;
        else if (ep != 0) m_rr = (g + 1) % N;
      end
    endcase
  endtask

  task automatic reset_mid();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_state", 32'(state), 32'h1);
    chk("rst_pop", 32'(pop), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_um_sup", 32'(um_sup), 32'(DSUP));
    model_reset();
    sb.delete();
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
  endtask

  // Monitor: registered outputs sampled just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && sb.size() > 0) begin
        e = sb.pop_front();
        chk("out_valid", 32'(out_valid), 32'(e.v));
        if (e.v) chk("out_src", 32'(out_src), 32'(e.src));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; init = 1'b0; cfg_sup = 3'd0; cfg_inf = 3'd0;
    fifo_empty = '1; fifo_alm_full = '0; down_alm_full = 1'b0;
    model_reset();
    #3;
    chk("init_state", 32'(state), 32'h1);
    chk("init_um_sup", 32'(um_sup), 32'(DSUP));
    chk("init_um_inf", 32'(um_inf), 32'(DINF));
    chk("init_pop", 32'(pop), 32'h0);
    chk("init_out_valid", 32'(out_valid), 32'h0);
    @(posedge clk);
    #2 reset = 1'b0;

    // Valid then rejected configuration.
    step(1, 3'd5, 3'd2, 4'b1111, 4'b0000, 0);
    step(1, 3'd5, 3'd2, 4'b1111, 4'b0000, 0);
    step(0, 3'd0, 3'd0, 4'b1111, 4'b0000, 0);
    step(1, 3'd2, 3'd3, 4'b1111, 4'b0000, 0);
    step(0, 3'd2, 3'd3, 4'b1111, 4'b0000, 0);
    step(0, 3'd0, 3'd0, 4'b1111, 4'b0000, 0);
    // All four non-empty: full rotation.
    repeat (7) step(0, 3'd0, 3'd0, 4'b0000, 4'b0000, 0);
    // Only FIFO 2 non-empty, then drains.
    repeat (3) step(0, 3'd0, 3'd0, 4'b1011, 4'b0000, 0);
    repeat (2) step(0, 3'd0, 3'd0, 4'b1111, 4'b0000, 0);
    // Downstream back-pressure mid-stream.
    repeat (3) step(0, 3'd0, 3'd0, 4'b0000, 4'b0000, 0);
    repeat (4) step(0, 3'd0, 3'd0, 4'b0000, 4'b0000, 1);
    repeat (3) step(0, 3'd0, 3'd0, 4'b0000, 4'b0000, 0);
    // init and down_alm_full together.
    step(1, 3'd7, 3'd0, 4'b0000, 4'b0000, 1);
    step(0, 3'd7, 3'd0, 4'b0000, 4'b0000, 1);
    repeat (3) step(0, 3'd0, 3'd0, 4'b0000, 4'b0000, 0);
    // Asynchronous reset while popping.
    reset_mid();
    step(0, 3'd0, 3'd0, 4'b0000, 4'b0000, 0);
    step(0, 3'd0, 3'd0, 4'b0000, 4'b0000, 0);
    step(0, 3'd0, 3'd0, 4'b0000, 4'b0000, 0);
    repeat (3) step(0, 3'd0, 3'd0, 4'b0000, 4'b0000, 0);
`ifdef FIFO_ALMFULL_PRIO_EN
    repeat (4) step(0, 3'd0, 3'd0, 4'b0110, 4'b1000, 0);
    repeat (4) step(0, 3'd0, 3'd0, 4'b0110, 4'b0000, 0);
`endif

    for (int k = 0; k < 400; k++) begin
      logic [N-1:0] emp;
      if (k == 200) reset_mid();
      emp = ($urandom_range(0, 4) == 0) ? '1 : N'($urandom);
      step($urandom_range(0, 19) == 0, 3'($urandom), 3'($urandom), emp,
           N'($urandom), $urandom_range(0, 3) == 0);
    end

    repeat (2) @(posedge clk);
    #2;
    chk("sb_drain", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_pop_arbiter.md
Name: fifo_pop_arbiter

Overview:
Controller for a bank of N 8x12b FIFOs.
- Drives the one-hot `state` bus the FIFOs decode: 0001 = reset, 0010 = threshold load.
- Distributes the almost-full/almost-empty thresholds to the FIFOs.
- Arbitrates pops round-robin onto one shared downstream consumer, which back-pressures with its own almost-full.
- Sits between the FIFO bank and the downstream stage.

Parameters:
N_FIFO, 4, number of FIFOs arbitrated (2..8).
DEF_SUP, 6, almost-full threshold (um_sup) loaded if no valid configuration is given.
DEF_INF, 1, almost-empty threshold (um_inf) loaded if no valid configuration is given.

Ports:
clk  input  1  clock; all state changes on rising edge.
reset  input  1  asynchronous, active-high reset.
init  input  1  request a threshold (re)configuration.
cfg_sup  input  3  requested almost-full threshold.
cfg_inf  input  3  requested almost-empty threshold.
fifo_empty  input  N_FIFO  per-FIFO empty flag.
fifo_alm_full  input  N_FIFO  per-FIFO alm_full flag.
down_alm_full  input  1  downstream almost-full; blocks all pops.
state  output  4  one-hot FIFO control bus.
um_sup  output  3  almost-full threshold to the FIFOs.
um_inf  output  3  almost-empty threshold to the FIFOs.
pop  output  N_FIFO  one-hot pop; combinational from registered state and inputs.
out_valid  output  1  registered; FIFO data_out is valid this cycle.
out_src  output  3  registered; index of the FIFO that produced the current data_out.
cfg_err  output  1  sticky; last configuration was rejected.

Behaviour:
- Reset (async): state=0001 (RESET), um_sup=DEF_SUP, um_inf=DEF_INF, rr_ptr=0, pop=0, out_valid=0, out_src=0, cfg_err=0.
- Reset asserted mid-operation: all of the above take effect immediately; a pop in flight is abandoned and out_valid drops at once.
- FSM, encoding = value driven on `state`:
  - RESET 0001: leave to INIT on the first clock edge after reset is released.
  - INIT 0010: the FIFOs latch um_sup/um_inf on every edge in this state.
    - On INIT entry, cfg_sup/cfg_inf are checked.
    - Valid (cfg_sup > cfg_inf and cfg_sup <= 7): um_sup=cfg_sup, um_inf=cfg_inf, cfg_err=0.
    - Invalid: previous thresholds are retained and cfg_err=1.
    - Stay in INIT while init=1; go to IDLE when init=0.
  - IDLE 0100: pop=0. Go to ACTIVE when any fifo_empty bit is 0. Go to INIT when init=1.
  - ACTIVE 1000, arbitration:
    - eligible = ~fifo_empty, or the pending mask under the optional feature.
    - If down_alm_full=0 and eligible is non-zero, pop drives one-hot the first eligible index searching upward from rr_ptr, wrapping at N_FIFO-1 to 0.
    - rr_ptr <= granted index + 1, wrapped.
    - If down_alm_full=1, pop=0 and rr_ptr holds.
  - ACTIVE exits: go to IDLE when eligible is zero. Go to INIT when init=1; init has priority and no pop is issued that cycle.
- Data returns one cycle after pop (FIFO read latency). On the next edge, out_valid <= |pop and out_src <= granted index.
- Pop is never issued to a FIFO whose empty bit is 1 in the same cycle.
- Back-to-back pops to the same FIFO are allowed only when it is the sole eligible FIFO.
- Simultaneous init and down_alm_full: init wins.
- Codes other than the four legal ones never appear on `state`. Any illegal internal encoding recovers to RESET on the next edge.

Optional Feature:
Macro name: FIFO_ALMFULL_PRIO_EN
- Defined: if any eligible FIFO has fifo_alm_full=1, arbitration is restricted to that subset. The same rr_ptr search applies within the subset. Otherwise arbitration is plain round-robin.
- Undefined: pure round-robin. fifo_alm_full is ignored, though the port stays present.

Test Plan:
- Reset pulse mid-ACTIVE -> state=0001, pop=0 and out_valid=0 asynchronously; state=0010 on the first edge after release; state=0100 once init=0.
- init=1 with cfg_sup=5, cfg_inf=2 -> um_sup=5, um_inf=2, cfg_err=0. Then init with cfg_sup=2, cfg_inf=3 -> um_sup stays 5, um_inf stays 2, cfg_err=1.
- All 4 FIFOs non-empty, down_alm_full=0 -> pop sequence 0001, 0010, 0100, 1000, 0001. out_src sequence 0,1,2,3,0, each one cycle after its pop.
- Only FIFO 2 non-empty for 3 cycles, then it empties -> pop=0100 three times; state returns to 0100 (IDLE) on the edge after fifo_empty is all-ones.
- down_alm_full=1 for 4 cycles mid-stream -> pop=0 and rr_ptr frozen; after release, the grant resumes at the next index in sequence.
- With FIFO_ALMFULL_PRIO_EN defined: FIFOs 0 and 3 non-empty, fifo_alm_full=1000 -> FIFO 3 granted every cycle until its alm_full drops, then alternation 0,3.
